fixed_div: RTL and testbench
============================

Name: fixed_div

Overview:
- Sequential signed fixed-point divider, Q2.14 (2 integer bits including sign, 14 fraction bits). Inverse companion to the fixed-point multiplier in the same datapath.
- Computes out = A_in / B_in using restoring division on operand magnitudes, one quotient bit per clock.
- Start/busy/done handshake; result saturates with overflow/underflow flags; divide-by-zero is detected and flagged.

Parameters:
- data_width, 16, operand/result width in bits.
- frac_width, 14, fraction bits of operands and result.
- int_width, 2, integer bits including sign; must equal data_width - frac_width.
- qwidth, 30, quotient iterations; must equal data_width + frac_width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- A_in  in  data_width  signed dividend, Q2.14.
- B_in  in  data_width  signed divisor, Q2.14.
- busy  out  1  high while a division is in progress.
- done  out  1  single-cycle pulse when the result is valid.
- out  out  data_width  signed quotient, Q2.14; held until the next result.
- overflow_flag  out  1  result saturated to the positive limit.
- underflow_flag  out  1  result saturated to the negative limit.
- div_by_zero  out  1  B was zero for the latest result.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, out=0, all flags=0; internal registers cleared. Reset mid-division aborts the operation with no done pulse.
- States: IDLE, DIV, FIN.
- IDLE + start=1 at edge k:
  - Latch sign = A[msb]^B[msb], |A| (16-bit unsigned, so |-2.0|=32768), and |B|. Set busy=1, clear the iteration counter.
  - Dividend = |A| << frac_width (30 bits).
  - If B==0, go to FIN instead of DIV.
- DIV: each edge shifts one dividend bit into the remainder (data_width+1 bits), trial-subtracts |B|, shifts the quotient bit in. Exactly qwidth edges (k+1 .. k+qwidth), then go to FIN.
- FIN, edge k+qwidth+1 (or k+1 for divide-by-zero):
  - Update out and all flags; done=1 for this one cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle after edge k+31 with default parameters. Back-to-back is allowed: start may be high in the cycle done is high and is accepted on the next edge.
- Arithmetic:
  - Magnitude quotient Q (30 bits), truncated toward zero.
  - Positive result (sign=0): Q > 32767 gives out=0x7FFF and overflow_flag=1; otherwise out=Q.
  - Negative result (sign=1): Q > 32768 gives out=0x8000 and underflow_flag=1; otherwise out=-Q (0x8000 exactly is legal, no flag).
  - Zero quotient with sign=1 gives out=0x0000.
- Divide-by-zero: div_by_zero=1.
  - A>0: out=0x7FFF, overflow_flag=1.
  - A<0: out=0x8000, underflow_flag=1.
  - A==0: out=0x0000, no overflow/underflow flag.
- Flags update only at FIN and hold until the next FIN or reset.
- start asserted while busy=1 is ignored. Operand changes after acceptance have no effect.

Test Plan:
- A=0x2000 (0.5), B=0x4000 (1.0), start pulse -> done exactly 31 cycles after the accepting edge, out=0x2000, all flags 0, busy high for the intervening cycles.
- A=0x4000, B=0x6000 (1.5) -> out=0x2AAA. A=0xC000 (-1.0), B=0x6000 -> out=0xD556 (truncation toward zero). A=0x1000, B=0xC000 -> out=0xF000.
- Saturation:
  - A=0x4000, B=0x2000 -> out=0x7FFF, overflow_flag=1.
  - A=0x8000, B=0x2000 -> out=0x8000, underflow_flag=1.
  - A=0x8000, B=0x4000 -> out=0x8000, no flags.
  - A=0x8000, B=0xC000 -> out=0x7FFF, overflow_flag=1.
- Divide-by-zero:
  - A=0x1234, B=0 -> done 2 cycles after start, out=0x7FFF, overflow_flag=1, div_by_zero=1.
  - A=0xF000, B=0 -> out=0x8000, underflow_flag=1, div_by_zero=1.
  - A=0, B=0 -> out=0, div_by_zero=1 only.
- Start pulses during busy with different operands -> ignored; the first result is unchanged, exactly one done pulse. A second start in the done cycle -> accepted, and its result follows 31 cycles later.
- Reset asserted at cycle 10 of a division -> next edge busy=0, out=0, flags=0, no done pulse; a new start afterwards completes correctly.

Source files
------------

// File: rtl/fixed_div_if.sv
// Start/busy/done handshake and operand/result bundle for the Q2.14 divider.
// Handshake: start is sampled only while busy is low; done is a one-cycle pulse and out/flags hold until the next done.
interface fixed_div_if #(
  parameter int data_width = 16
);
  logic                  start;
  logic [data_width-1:0] A_in;
  logic [data_width-1:0] B_in;
  logic                  busy;
  logic                  done;
  logic [data_width-1:0] out;
  logic                  overflow_flag;
  logic                  underflow_flag;
  logic                  div_by_zero;

  modport master (
    output start, A_in, B_in,
    input  busy, done, out, overflow_flag, underflow_flag, div_by_zero
  );

  modport slave (
    input  start, A_in, B_in,
    output busy, done, out, overflow_flag, underflow_flag, div_by_zero
  );
endinterface

// File: rtl/fixed_div.sv
// Sequential signed Q2.14 divider: restoring division on magnitudes, one quotient bit per clock,
// with saturation and divide-by-zero handling applied when the result is published.
module fixed_div #(
  parameter int data_width = 16,
  parameter int frac_width = 14,
  parameter int int_width  = 2,
  parameter int qwidth     = 30
) (
  input  logic       clk,
  input  logic       reset,
  fixed_div_if.slave bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int cw = $clog2(qwidth + 1);
  localparam logic [qwidth-1:0] pos_lim = qwidth'((1 << (int_width + frac_width - 1)) - 1);
  localparam logic [qwidth-1:0] neg_lim = qwidth'(1 << (int_width + frac_width - 1));
  localparam logic [data_width-1:0] pos_sat = {1'b0, {(data_width-1){1'b1}}};
  localparam logic [data_width-1:0] neg_sat = {1'b1, {(data_width-1){1'b0}}};

  state_t state, state_nx;

  logic [cw-1:0]         cnt;
  logic [data_width-1:0] a_mag, b_mag, b_lat;
  logic [qwidth-1:0]     dvd, quo;
  logic [data_width:0]   rem, rem_sh, rem_diff;
  logic                  q_bit;
  logic                  sign, dz, a_neg, a_zero;
  logic                  load, step, finish;
  logic                  done_q;
  logic [data_width-1:0] out_q, res_out;
  logic                  ovf_q, udf_q, dz_q, res_ovf, res_udf;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.B_in == '0) ? FIN : DIV;
      DIV:  if (cnt == cw'(qwidth - 1)) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    load   = bus.start;
      DIV:     step   = 1'b1;
      FIN:     finish = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;
  assign bus.out            = out_q;
  assign bus.overflow_flag  = ovf_q;
  assign bus.underflow_flag = udf_q;
  assign bus.div_by_zero    = dz_q;
  assign state_dbg          = state;

  // |-2.0| = 0x8000 still fits because magnitudes are treated as unsigned
  assign a_mag = bus.A_in[data_width-1] ? (~bus.A_in + 1'b1) : bus.A_in;
  assign b_mag = bus.B_in[data_width-1] ? (~bus.B_in + 1'b1) : bus.B_in;

  assign rem_sh   = {rem[data_width-1:0], dvd[qwidth-1]};
  assign q_bit    = (rem_sh >= {1'b0, b_lat});
  assign rem_diff = rem_sh - {1'b0, b_lat};

  always_comb begin
    res_out = '0;
    res_ovf = 1'b0;
    res_udf = 1'b0;
    if (dz) begin
      if (a_zero) begin
        res_out = '0;
      end else if (a_neg) begin
        res_out = neg_sat;
        res_udf = 1'b1;
      end else begin
        res_out = pos_sat;
        res_ovf = 1'b1;
      end
    end else if (!sign) begin
      if (quo > pos_lim) begin
        res_out = pos_sat;
        res_ovf = 1'b1;
      end else begin
        res_out = quo[data_width-1:0];
      end
    end else begin
      // A magnitude of exactly 2.0 negates to 0x8000, the legal negative limit
      if (quo > neg_lim) begin
        res_out = neg_sat;
        res_udf = 1'b1;
      end else begin
        res_out = ~quo[data_width-1:0] + 1'b1;
      end
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      b_lat  <= '0;
      dvd    <= '0;
      quo    <= '0;
      rem    <= '0;
      sign   <= 1'b0;
      dz     <= 1'b0;
      a_neg  <= 1'b0;
      a_zero <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        cnt    <= '0;
        b_lat  <= b_mag;
        dvd    <= qwidth'(a_mag) << frac_width;
        quo    <= '0;
        rem    <= '0;
        sign   <= bus.A_in[data_width-1] ^ bus.B_in[data_width-1];
        dz     <= (bus.B_in == '0);
        a_neg  <= bus.A_in[data_width-1];
        a_zero <= (bus.A_in == '0);
      end
      if (step) begin
        cnt <= cnt + 1'b1;
        dvd <= {dvd[qwidth-2:0], 1'b0};
        quo <= {quo[qwidth-2:0], q_bit};
        rem <= q_bit ? rem_diff : rem_sh;
      end
      if (finish) begin
        done_q <= 1'b1;
        out_q  <= res_out;
        ovf_q  <= res_ovf;
        udf_q  <= res_udf;
        dz_q   <= dz;
      end
    end
  end

endmodule

// File: tb/tb_fixed_div.sv
// Directed bench for fixed_div: hand-computed Q2.14 quotients, saturation, divide-by-zero,
// handshake latency, ignored starts, back-to-back starts and mid-division reset.
module tb_fixed_div;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         n_checks;
  int         n_errors;

  fixed_div_if #(.data_width(16)) bus ();

  fixed_div dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, bus.overflow_flag, bus.underflow_flag, bus.div_by_zero};
  endfunction

  // Called at a negedge: present operands, let the next posedge accept them.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    bus.A_in  = a;
    bus.B_in  = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // lat = number of edges after the accepting edge at which done was seen.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_div(input logic [15:0] a, input logic [15:0] b, output int lat,
                         output logic busy_ok);
    @(negedge clk);
    launch(a, b);
    wait_done(lat, busy_ok);
  endtask

  logic [15:0] va[11];
  logic [15:0] vb[11];
  logic [15:0] vo[11];
  logic [2:0]  vf[11];

  initial begin
    int   lat;
    logic busy_ok;
    int   dones;
    logic [15:0] seen_out;

    n_checks = 0;
    n_errors = 0;
    bus.start = 1'b0;
    bus.A_in  = '0;
    bus.B_in  = '0;

    // {A, B, expected out, expected {ovf, udf, dz}}
    va[0]  = 16'h2000; vb[0]  = 16'h4000; vo[0]  = 16'h2000; vf[0]  = 3'b000;
    va[1]  = 16'h4000; vb[1]  = 16'h6000; vo[1]  = 16'h2AAA; vf[1]  = 3'b000;
    va[2]  = 16'hC000; vb[2]  = 16'h6000; vo[2]  = 16'hD556; vf[2]  = 3'b000;
    va[3]  = 16'h1000; vb[3]  = 16'hC000; vo[3]  = 16'hF000; vf[3]  = 3'b000;
    va[4]  = 16'h4000; vb[4]  = 16'h2000; vo[4]  = 16'h7FFF; vf[4]  = 3'b100;
    va[5]  = 16'h8000; vb[5]  = 16'h2000; vo[5]  = 16'h8000; vf[5]  = 3'b010;
    va[6]  = 16'h8000; vb[6]  = 16'h4000; vo[6]  = 16'h8000; vf[6]  = 3'b000;
    va[7]  = 16'h8000; vb[7]  = 16'hC000; vo[7]  = 16'h7FFF; vf[7]  = 3'b100;
    va[8]  = 16'h1234; vb[8]  = 16'h0000; vo[8]  = 16'h7FFF; vf[8]  = 3'b101;
    va[9]  = 16'hF000; vb[9]  = 16'h0000; vo[9]  = 16'h8000; vf[9]  = 3'b011;
    va[10] = 16'h0000; vb[10] = 16'h0000; vo[10] = 16'h0000; vf[10] = 3'b001;

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_out", {16'd0, bus.out}, 32'd0);
    check("rst_flags", flags(), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_div(va[i], vb[i], lat, busy_ok);
      check($sformatf("lat_%0d", i), lat, (vb[i] == 16'd0) ? 32'd1 : 32'd31);
      check($sformatf("busy_during_%0d", i), {31'd0, busy_ok}, 32'd1);
      check($sformatf("busy_at_done_%0d", i), {31'd0, bus.busy}, 32'd0);
      check($sformatf("out_%0d", i), {16'd0, bus.out}, {16'd0, vo[i]});
      check($sformatf("flags_%0d", i), flags(), {29'd0, vf[i]});
      @(negedge clk);
      check($sformatf("done_pulse_%0d", i), {31'd0, bus.done}, 32'd0);
      check($sformatf("out_hold_%0d", i), {16'd0, bus.out}, {16'd0, vo[i]});
    end

    // Starts while busy with other operands must be ignored.
    @(negedge clk);
    launch(16'h2000, 16'h4000);
    dones    = 0;
    seen_out = '0;
    for (int c = 1; c < 45; c++) begin
      if (c == 3 || c == 10 || c == 20) begin
        bus.A_in  = 16'h4000;
        bus.B_in  = 16'h2000;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done) begin
        dones++;
        seen_out = bus.out;
      end
    end
    bus.start = 1'b0;
    check("ign_done_count", dones, 32'd1);
    check("ign_out", {16'd0, seen_out}, 32'h2000);
    check("ign_flags", flags(), 32'd0);

    // Back-to-back: a start presented in the done cycle is accepted.
    run_div(16'h4000, 16'h6000, lat, busy_ok);
    check("b2b_first_out", {16'd0, bus.out}, 32'h2AAA);
    check("b2b_first_done", {31'd0, bus.done}, 32'd1);
    launch(16'hC000, 16'h6000);
    wait_done(lat, busy_ok);
    check("b2b_lat", lat, 32'd31);
    check("b2b_out", {16'd0, bus.out}, 32'hD556);

    // Reset in the middle of a division aborts it and clears the result.
    run_div(16'h4000, 16'h2000, lat, busy_ok);
    check("pre_rst_flags", flags(), 32'd4);
    @(negedge clk);
    launch(16'h2000, 16'h4000);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("mid_rst_done", {31'd0, bus.done}, 32'd0);
    check("mid_rst_out", {16'd0, bus.out}, 32'd0);
    check("mid_rst_flags", flags(), 32'd0);
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("mid_rst_no_done", dones, 32'd0);
    run_div(16'h1000, 16'hC000, lat, busy_ok);
    check("post_rst_lat", lat, 32'd31);
    check("post_rst_out", {16'd0, bus.out}, 32'hF000);
    check("post_rst_flags", flags(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
